// File: rtl/stage_pipe_reg.sv
// Decode-to-execute pipeline register with a two-entry skid buffer, flush
// (bubble) insertion and saturating bubble/stall performance counters.
module stage_pipe_reg #(
    parameter int               DATA_W    = 64,
    parameter int               REG_W     = 4,
    parameter int               CNT_W     = 16,
    parameter logic [3:0]       NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0] NREG      = '1,
    parameter logic [2:0]       SAOK      = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        D_stat_i,
    input  logic [3:0]        D_icode_i,
    input  logic [3:0]        D_ifun_i,
    input  logic [DATA_W-1:0] D_valC_i,
    input  logic [DATA_W-1:0] d_valA_i,
    input  logic [DATA_W-1:0] d_valB_i,
    input  logic [REG_W-1:0]  d_dstE_i,
    input  logic [REG_W-1:0]  d_dstM_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2:0]        E_stat_o,
    output logic [3:0]        E_icode_o,
    output logic [3:0]        E_ifun_o,
    output logic [DATA_W-1:0] E_valC_o,
    output logic [DATA_W-1:0] E_valA_o,
    output logic [DATA_W-1:0] E_valB_o,
    output logic [REG_W-1:0]  E_dstE_o,
    output logic [REG_W-1:0]  E_dstM_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [REG_W-1:0]  dste;
        logic [REG_W-1:0]  dstm;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam entry_t BUBBLE = '{stat: SAOK, icode: NOP_ICODE, ifun: 4'h0,
                                  valc: '0, vala: '0, valb: '0,
                                  dste: NREG, dstm: NREG};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state;
    entry_t           head_p0;
    entry_t           skid_p0;
    entry_t           in_ent;
    entry_t           out_ent;
    logic             accept;
    logic             drain;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;

    assign in_ent = '{stat: D_stat_i, icode: D_icode_i, ifun: D_ifun_i,
                      valc: D_valC_i, vala: d_valA_i, valb: d_valB_i,
                      dste: d_dstE_i, dstm: d_dstM_i};

    assign in_ready_o  = (state == EMPTY || state == ONE) && !rst;
    assign out_valid_o = (state == ONE || state == FULL);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;
    assign stall       = out_valid_o & ~out_ready_i & ~bubble_i;

    // Control: occupancy FSM and counters; bubble overrides every handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else if (bubble_i) begin
            state      <= EMPTY;
            bubble_cnt <= sat_inc(bubble_cnt);
        end else begin
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !drain)
                        state <= FULL;
                    else if (!accept && drain)
                        state <= EMPTY;
                end
                FULL:    if (drain) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Data: head/skid storage, no reset since outputs are masked when empty
    always_ff @(posedge clk) begin
        if (!bubble_i) begin
            case (state)
                EMPTY: if (accept) head_p0 <= in_ent;
                ONE: begin
                    if (accept && drain)
                        head_p0 <= in_ent;
                    else if (accept)
                        skid_p0 <= in_ent;
                end
                FULL:    if (drain) head_p0 <= skid_p0;
                default: ;
            endcase
        end
    end

    assign out_ent      = out_valid_o ? head_p0 : BUBBLE;
    assign E_stat_o     = out_ent.stat;
    assign E_icode_o    = out_ent.icode;
    assign E_ifun_o     = out_ent.ifun;
    assign E_valC_o     = out_ent.valc;
    assign E_valA_o     = out_ent.vala;
    assign E_valB_o     = out_ent.valb;
    assign E_dstE_o     = out_ent.dste;
    assign E_dstM_o     = out_ent.dstm;
    assign occ_o        = state;
    assign bubble_cnt_o = bubble_cnt;
    assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Scoreboard bench for stage_pipe_reg: a reference queue model predicts
// handshakes, head contents, occupancy and saturating counters every cycle.
module tb_stage_pipe_reg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 4;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [REG_W-1:0]  dste;
        logic [REG_W-1:0]  dstm;
    } ent_t;

    localparam ent_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                valc: '0, vala: '0, valb: '0,
                                dste: 4'hF, dstm: 4'hF};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bubble_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              out_ready_i = 1'b0;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [2:0]        E_stat_o;
    logic [3:0]        E_icode_o;
    logic [3:0]        E_ifun_o;
    logic [DATA_W-1:0] E_valC_o;
    logic [DATA_W-1:0] E_valA_o;
    logic [DATA_W-1:0] E_valB_o;
    logic [REG_W-1:0]  E_dstE_o;
    logic [REG_W-1:0]  E_dstM_o;
    logic [1:0]        occ_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    ent_t              cur = '0;

    ent_t              q[$];
    logic [CNT_W-1:0]  m_bcnt = '0;
    logic [CNT_W-1:0]  m_scnt = '0;
    bit                chk_en = 1'b0;
    int                n_tests = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    stage_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bubble_i(bubble_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .D_stat_i(cur.stat), .D_icode_i(cur.icode), .D_ifun_i(cur.ifun),
        .D_valC_i(cur.valc), .d_valA_i(cur.vala), .d_valB_i(cur.valb),
        .d_dstE_i(cur.dste), .d_dstM_i(cur.dstm),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
        .E_valC_o(E_valC_o), .E_valA_o(E_valA_o), .E_valB_o(E_valB_o),
        .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .occ_o(occ_o),
        .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.stat  = 3'($urandom);
        e.icode = 4'($urandom);
        e.ifun  = 4'($urandom);
        e.valc  = {$urandom, $urandom};
        e.vala  = {$urandom, $urandom};
        e.valb  = {$urandom, $urandom};
        e.dste  = 4'($urandom);
        e.dstm  = 4'($urandom);
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // One cycle: drive at negedge, compare against the model, then advance the model
    task automatic step(input bit r, input bit b, input bit iv, input bit ord, input ent_t e);
        int   pre;
        ent_t h;
        @(negedge clk);
        rst = r; bubble_i = b; in_valid_i = iv; out_ready_i = ord; cur = e;
        #1;
        chk("in_ready", 64'(in_ready_o), 64'(!r && q.size() < 2));
        if (chk_en) begin
            h = (q.size() > 0) ? q[0] : BUBBLE;
            chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
            chk("occ",       64'(occ_o),       64'(q.size()));
            chk("E_stat",    64'(E_stat_o),    64'(h.stat));
            chk("E_icode",   64'(E_icode_o),   64'(h.icode));
            chk("E_ifun",    64'(E_ifun_o),    64'(h.ifun));
            chk("E_valC",    E_valC_o,         h.valc);
            chk("E_valA",    E_valA_o,         h.vala);
            chk("E_valB",    E_valB_o,         h.valb);
            chk("E_dstE",    64'(E_dstE_o),    64'(h.dste));
            chk("E_dstM",    64'(E_dstM_o),    64'(h.dstm));
            chk("bubble_cnt", 64'(bubble_cnt_o), 64'(m_bcnt));
            chk("stall_cnt",  64'(stall_cnt_o),  64'(m_scnt));
        end
        pre = q.size();
        if (r) begin
            q.delete(); m_bcnt = '0; m_scnt = '0;
        end else if (b) begin
            q.delete(); m_bcnt = sat(m_bcnt);
        end else begin
            if (pre > 0 && !ord) m_scnt = sat(m_scnt);
            if (pre > 0 && ord) void'(q.pop_front());
            if (iv && pre < 2) q.push_back(e);
        end
        chk_en = 1'b1;
    endtask

    initial begin
        ent_t e, a, b, c;
        step(1, 0, 0, 0, rnd_ent());
        step(1, 0, 0, 0, rnd_ent());

        // Single-cycle latency through an empty stage
        e = rnd_ent(); e.icode = 4'd6; e.vala = 64'd5;
        step(0, 0, 1, 1, e);
        step(0, 0, 0, 1, rnd_ent());
        chk("lat_icode", 64'(E_icode_o), 64'd6);
        chk("lat_valA",  E_valA_o, 64'd5);
        chk("lat_occ",   64'(occ_o), 64'd1);

        // Back-pressure: A, B fill the stage, C waits, then all drain in order
        a = rnd_ent(); b = rnd_ent(); c = rnd_ent();
        step(0, 0, 1, 0, a);
        step(0, 0, 1, 0, b);
        step(0, 0, 1, 0, c);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        chk("full_occ",      64'(occ_o), 64'd2);
        step(0, 0, 1, 0, c);
        step(0, 0, 1, 1, c);
        step(0, 0, 1, 1, c);
        step(0, 0, 0, 1, rnd_ent());
        step(0, 0, 0, 1, rnd_ent());

        // Flush while full with a simultaneous offer and drain
        step(0, 0, 1, 0, rnd_ent());
        step(0, 0, 1, 0, rnd_ent());
        step(0, 1, 1, 1, rnd_ent());
        step(0, 0, 0, 0, rnd_ent());
        chk("flush_occ",   64'(occ_o), 64'd0);
        chk("flush_icode", 64'(E_icode_o), 64'h1);
        chk("flush_dstE",  64'(E_dstE_o), 64'hF);
        chk("flush_bcnt",  64'(bubble_cnt_o), 64'd1);

        // Stall counter saturation
        step(0, 0, 1, 0, rnd_ent());
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, rnd_ent());
        chk("stall_sat", 64'(stall_cnt_o), 64'd15);

        // Reset beats bubble while full; in_ready held low during reset
        step(0, 0, 1, 1, rnd_ent());
        step(0, 0, 1, 0, rnd_ent());
        step(1, 1, 1, 0, rnd_ent());
        step(1, 0, 1, 0, rnd_ent());
        chk("rst_occ",  64'(occ_o), 64'd0);
        chk("rst_bcnt", 64'(bubble_cnt_o), 64'd0);
        chk("rst_scnt", 64'(stall_cnt_o), 64'd0);
        step(0, 0, 0, 0, rnd_ent());

        // Random traffic against the reference queue
        for (int i = 0; i < 10000; i++)
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), rnd_ent());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
